adc_frame_seq: RTL and testbench

// - Sequences a dual-channel serial ADC (Pmod AD1 style: cs_n, sclk, sdata0/1) for the VU meter front end.
// - Generates the sample-rate tick and gates a divided serial clock for exactly FRAME_BITS periods per frame.
// - Delivers one 12-bit sample pair per frame to the level-detect path over a valid/ready handshake.
// - Sits between the ADC pins and the peak/level logic; all logic runs on clk_in.

---
 rtl/adc_frame_seq_pkg.sv | 24 ++
 rtl/adc_frame_seq_if.sv | 31 +++
 rtl/adc_frame_seq_phase.sv | 50 +++++
 rtl/adc_frame_seq.sv | 190 +++++++++++++++++++
 tb/tb_adc_frame_seq.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_frame_seq_pkg.sv
// adc_frame_seq_pkg
// Shared types and helpers for the dual-channel serial ADC frame sequencer.
// - seqState_t : 3-bit FSM state encoding used by the top level
// - cntWidth   : counter width for a given maximum count value
// - DEF_DATA_BITS : default sample width shared by the sample interface
package adc_frame_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_QUIET = 3'd4
  } seqState_t;

  localparam int DEF_DATA_BITS = 12;

  // One spare bit above $clog2 keeps the maximum value representable
  // even when it is an exact power of two.
  function automatic int cntWidth(input int maxVal);
    return $clog2(maxVal) + 1;
  endfunction

endpackage

// File: rtl/adc_frame_seq_if.sv
// adc_frame_seq_if
// Sample-pair handshake between the ADC sequencer and the level-detect path.
// - sample0/sample1 : unsigned channel samples, stable while sample_valid is high
// - sample_valid    : pair available (driven by master)
// - sample_ready    : consumer accepts the pair when valid && ready (driven by slave)
interface adc_frame_seq_if
  import adc_frame_seq_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic [DATA_BITS-1:0] sample0;
  logic [DATA_BITS-1:0] sample1;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (
    output sample0,
    output sample1,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample0,
    input  sample1,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/adc_frame_seq_phase.sv
// sclk_phase_gen
// Gated half-period counter that produces the ADC serial clock.
// - clk_in, reset : system clock, async active-high reset
// - i_run         : 1 = toggle sclk every HALF cycles (first toggle is a fall);
//                   0 = hold sclk high and clear the counter
// - o_sclkFf      : registered serial clock
// - o_risePulse   : high in the cycle whose closing edge drives sclk 0->1
// - o_fallPulse   : high in the cycle whose closing edge drives sclk 1->0
module sclk_phase_gen
  import adc_frame_seq_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic i_run,
  output logic o_sclkFf,
  output logic o_risePulse,
  output logic o_fallPulse
);

  localparam int CNT_W = cntWidth(HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclkFf;
  logic             w_wrap;

  assign w_wrap      = (r_cnt == CNT_W'(HALF - 1));
  assign o_risePulse = i_run && w_wrap && !r_sclkFf;
  assign o_fallPulse = i_run && w_wrap && r_sclkFf;
  assign o_sclkFf    = r_sclkFf;

  // Half-period counter; sclk flips on each wrap, so the pulses above mark
  // the edge at which the new sclk level is registered.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_sclkFf <= 1'b1;
    end else if (!i_run) begin
      r_cnt    <= '0;
      r_sclkFf <= 1'b1;
    end else if (w_wrap) begin
      r_cnt    <= '0;
      r_sclkFf <= ~r_sclkFf;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_frame_seq.sv
// adc_frame_seq
// Sequences a Pmod AD1 style dual serial ADC: sample-rate tick, cs_n framing,
// gated sclk for FRAME_BITS periods, and delivery of one sample pair per frame.
// - clk_in, reset     : system clock, async active-high reset
// - i_enable          : start frames on ticks; 0 finishes the current frame then idles
// - i_sdata0/i_sdata1 : ADC serial data, channel 0/1
// - o_csN, o_sclk     : ADC chip select (active low) and serial clock (idles high)
// - o_overrun         : 1-cycle pulse when an unaccepted pair is overwritten
// - o_tickMissed      : sticky, a tick arrived while a frame was busy
// - o_smp             : sample pair valid/ready handshake (master side)
module adc_frame_seq
  import adc_frame_seq_pkg::*;
#(
  parameter int IN_FREQ      = 100_000_000,
  parameter int SCLK_FREQ    = 12_500_000,
  parameter int SAMPLE_FREQ  = 48_000,
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int QUIET_HALVES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic i_enable,
  input  logic i_sdata0,
  input  logic i_sdata1,
  output logic o_csN,
  output logic o_sclk,
  output logic o_overrun,
  output logic o_tickMissed,
  adc_frame_seq_if.master o_smp
);

  localparam int HALF      = IN_FREQ / (2 * SCLK_FREQ);
  localparam int TICK_MAX  = IN_FREQ / SAMPLE_FREQ;
  localparam int QUIET_CYC = QUIET_HALVES * HALF;
  localparam int TICK_W    = cntWidth(TICK_MAX - 1);
  localparam int BIT_W     = cntWidth(FRAME_BITS);
  localparam int WAIT_W    = cntWidth((QUIET_CYC > HALF) ? QUIET_CYC : HALF);

  logic [TICK_W-1:0]    r_tickCnt;
  logic                 w_tick;
  seqState_t            r_state;
  logic [WAIT_W-1:0]    r_waitCnt;
  logic [BIT_W-1:0]     r_bitCnt;
  logic                 r_bitOpen;
  logic [DATA_BITS-2:0] r_shift0;
  logic [DATA_BITS-2:0] r_shift1;
  logic [DATA_BITS-1:0] w_next0;
  logic [DATA_BITS-1:0] w_next1;
  logic [DATA_BITS-1:0] r_sample0;
  logic [DATA_BITS-1:0] r_sample1;
  logic                 r_csN;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_tickMissed;
  logic                 w_run;
  logic                 w_sclkFf;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_shiftEn;

  assign w_tick = (r_tickCnt == TICK_W'(TICK_MAX - 1));

  // Free-running sample-rate counter, independent of enable so the frame
  // rate never drifts when enable toggles.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + TICK_W'(1);
    end
  end

  assign w_run = (r_state == ST_SHIFT);

  sclk_phase_gen #(
    .HALF (HALF)
  ) u_phase (
    .clk_in      (clk_in),
    .reset       (reset),
    .i_run       (w_run),
    .o_sclkFf    (w_sclkFf),
    .o_risePulse (w_rise),
    .o_fallPulse (w_fall)
  );

  // Only the bits that can still reach the sample are kept; the incoming bit
  // is appended combinationally so the last rise can load the sample directly.
  assign w_next0 = {r_shift0, i_sdata0};
  assign w_next1 = {r_shift1, i_sdata1};

  // A bit is captured only after sclk has fallen for it, so a rise can never
  // be counted without the ADC having presented fresh data.
  assign w_shiftEn = w_rise && r_bitOpen;

  // Frame FSM plus output handshake. The sample pair, valid, overrun and the
  // cs_n release are registered on the final rising sclk edge, which puts
  // them on the outputs during the LOAD cycle itself.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_csN        <= 1'b1;
      r_waitCnt    <= '0;
      r_bitCnt     <= '0;
      r_bitOpen    <= 1'b0;
      r_shift0     <= '0;
      r_shift1     <= '0;
      r_sample0    <= '0;
      r_sample1    <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_tickMissed <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && o_smp.sample_ready) begin
        r_valid <= 1'b0;
      end
      if (w_tick && (r_state != ST_IDLE)) begin
        r_tickMissed <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_tick && i_enable) begin
            r_state   <= ST_SETUP;
            r_csN     <= 1'b0;
            r_waitCnt <= '0;
          end
        end
        ST_SETUP: begin
          if (r_waitCnt == WAIT_W'(HALF - 1)) begin
            r_state   <= ST_SHIFT;
            r_waitCnt <= '0;
            r_bitCnt  <= '0;
            r_bitOpen <= 1'b0;
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (w_fall) begin
            r_bitOpen <= 1'b1;
          end
          if (w_shiftEn) begin
            r_bitOpen <= 1'b0;
            r_shift0  <= w_next0[DATA_BITS-2:0];
            r_shift1  <= w_next1[DATA_BITS-2:0];
            if (r_bitCnt == BIT_W'(FRAME_BITS - 1)) begin
              r_state   <= ST_LOAD;
              r_csN     <= 1'b1;
              r_bitCnt  <= '0;
              r_sample0 <= w_next0;
              r_sample1 <= w_next1;
              r_valid   <= 1'b1;
              r_overrun <= r_valid && !o_smp.sample_ready;
            end else begin
              r_bitCnt <= r_bitCnt + BIT_W'(1);
            end
          end
        end
        ST_LOAD: begin
          r_state   <= ST_QUIET;
          r_waitCnt <= '0;
        end
        ST_QUIET: begin
          if (r_waitCnt == WAIT_W'(QUIET_CYC - 1)) begin
            r_state   <= ST_IDLE;
            r_waitCnt <= '0;
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_csN   <= 1'b1;
        end
      endcase
    end
  end

  assign o_csN              = r_csN;
  assign o_sclk             = w_sclkFf;
  assign o_overrun          = r_overrun;
  assign o_tickMissed       = r_tickMissed;
  assign o_smp.sample0      = r_sample0;
  assign o_smp.sample1      = r_sample1;
  assign o_smp.sample_valid = r_valid;

endmodule

// File: tb/tb_adc_frame_seq.sv
// tb_adc_frame_seq
// Scoreboard bench for adc_frame_seq. A default-rate instance is driven
// through directed frames; a second instance with a 1 MHz frame rate
// exercises dropped ticks and inter-frame cs_n spacing.
module tb_adc_frame_seq;

  typedef struct {
    logic [11:0] s0;
    logic [11:0] s1;
  } pair_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic reset, enable, sdata0, sdata1, csN, sclk, overrun, tickMissed;
  logic resetF, enableF, sdataF0, sdataF1, csNF, sclkF, overrunF, tickMissedF;

  adc_frame_seq_if #(.DATA_BITS(12)) smpIf ();
  adc_frame_seq_if #(.DATA_BITS(12)) smpF ();

  adc_frame_seq dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .i_enable     (enable),
    .i_sdata0     (sdata0),
    .i_sdata1     (sdata1),
    .o_csN        (csN),
    .o_sclk       (sclk),
    .o_overrun    (overrun),
    .o_tickMissed (tickMissed),
    .o_smp        (smpIf)
  );

  adc_frame_seq #(.SAMPLE_FREQ(1_000_000)) dutFast (
    .clk_in       (clk_in),
    .reset        (resetF),
    .i_enable     (enableF),
    .i_sdata0     (sdataF0),
    .i_sdata1     (sdataF1),
    .o_csN        (csNF),
    .o_sclk       (sclkF),
    .o_overrun    (overrunF),
    .o_tickMissed (tickMissedF),
    .o_smp        (smpF)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  pair_t expQ[$];

  logic [15:0] word0 = '0, word1 = '0;
  int bitIdx = 15;
  int bitIdxF = 15;
  localparam logic [15:0] WORD_F0 = 16'h05A3;
  localparam logic [15:0] WORD_F1 = 16'h0C7E;

  logic prevCsn = 1'b1, prevSclk = 1'b1, prevValid = 1'b0, prevCsnF = 1'b1;
  int sclkRises = 0, csFallCyc = -1, csFalls = 0, lastRise = -1;
  int overrunCount = 0, lastRiseF = -1, fastFrames = 0;
  bit periodOn = 1'b0;
  logic [11:0] expOverrunS0 = '0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] w0, input logic [11:0] w1, input bit push);
    pair_t p;
    word0 = {4'h0, w0};
    word1 = {4'h0, w1};
    if (push) begin
      p.s0 = w0;
      p.s1 = w1;
      expQ.push_back(p);
    end
  endtask

  task automatic waitCsn(input logic level, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_in);
      if (csN === level) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("csnWait", {31'd0, seen}, 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (expQ.size() == 0) break;
      @(negedge clk_in);
    end
    checkOutput("queueDrained", expQ.size(), 0);
  endtask

  task automatic runFrame(input logic [11:0] w0, input logic [11:0] w1, input bit push);
    applyStimulus(w0, w1, push);
    waitCsn(1'b0, 3000);
    waitCsn(1'b1, 400);
  endtask

  // ADC models: the next bit appears on each sclk fall, MSB first; cs_n high rewinds.
  always @(negedge sclk or posedge csN) begin
    if (csN) bitIdx = 15;
    else begin
      sdata0 = word0[bitIdx];
      sdata1 = word1[bitIdx];
      bitIdx = bitIdx - 1;
    end
  end

  always @(negedge sclkF or posedge csNF) begin
    if (csNF) bitIdxF = 15;
    else begin
      sdataF0 = WORD_F0[bitIdxF];
      sdataF1 = WORD_F1[bitIdxF];
      bitIdxF = bitIdxF - 1;
    end
  end

  // Monitor for the default-rate instance: frame timing and scoreboard pops.
  always @(negedge clk_in) begin
    pair_t p;
    if (reset) begin
      prevCsn = 1'b1;
      prevSclk = 1'b1;
      prevValid = 1'b0;
      sclkRises = 0;
      csFallCyc = -1;
    end else begin
      if (sclk && !prevSclk && !prevCsn) sclkRises++;
      if (!csN && prevCsn) begin
        csFallCyc = cyc;
        csFalls++;
        sclkRises = 0;
      end
      if (csN && !prevCsn) checkOutput("sclkRisesPerFrame", sclkRises, 16);
      if (smpIf.sample_valid && !prevValid) begin
        if (csFallCyc >= 0) checkOutput("validLatency", cyc - csFallCyc, 132);
        if (periodOn && lastRise >= 0) checkOutput("framePeriod", cyc - lastRise, 2083);
        lastRise = cyc;
      end
      if (overrun) begin
        overrunCount++;
        checkOutput("overrunSample0", {20'd0, smpIf.sample0}, {20'd0, expOverrunS0});
      end
      if (smpIf.sample_valid && smpIf.sample_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedPair: actual=%h/%h required=none",
                   smpIf.sample0, smpIf.sample1);
        end else begin
          p = expQ.pop_front();
          checkOutput("pairSample0", {20'd0, smpIf.sample0}, {20'd0, p.s0});
          checkOutput("pairSample1", {20'd0, smpIf.sample1}, {20'd0, p.s1});
        end
      end
      prevCsn = csN;
      prevSclk = sclk;
      prevValid = smpIf.sample_valid;
    end
  end

  // Monitor for the fast-rate instance: spacing between frames and data.
  always @(negedge clk_in) begin
    if (resetF) begin
      prevCsnF = 1'b1;
      lastRiseF = -1;
    end else begin
      if (!csNF && prevCsnF) begin
        if (lastRiseF >= 0) checkOutput("fastCsnGapAtLeast8", {31'd0, (cyc - lastRiseF) >= 8}, 32'd1);
        fastFrames++;
      end
      if (csNF && !prevCsnF) lastRiseF = cyc;
      if (smpF.sample_valid && smpF.sample_ready) begin
        checkOutput("fastSample0", {20'd0, smpF.sample0}, 32'h5A3);
        checkOutput("fastSample1", {20'd0, smpF.sample1}, 32'hC7E);
      end
      prevCsnF = csNF;
    end
  end

  // Directed sequence: reset state, steady frames, overrun, mid-frame reset,
  // and enable dropped mid-frame.
  initial begin
    logic [11:0] vec0 [10];
    logic [11:0] vec1 [10];
    int fallsBefore;
    int nRise;
    logic prevS;
    vec0 = '{12'hA5C, 12'hFFF, 12'h000, 12'h123, 12'h800, 12'h555, 12'h7FF, 12'h001, 12'hABC, 12'h3C3};
    vec1 = '{12'h3F1, 12'h000, 12'hFFF, 12'h456, 12'h001, 12'hAAA, 12'h800, 12'hFFE, 12'hDEF, 12'hC3C};

    reset = 1'b1;
    resetF = 1'b1;
    enable = 1'b0;
    enableF = 1'b1;
    smpIf.sample_ready = 1'b0;
    smpF.sample_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("resetCsn", csN, 1);
    checkOutput("resetSclk", sclk, 1);
    checkOutput("resetValid", smpIf.sample_valid, 0);
    checkOutput("resetSample0", {20'd0, smpIf.sample0}, 0);
    checkOutput("resetSample1", {20'd0, smpIf.sample1}, 0);
    checkOutput("resetOverrun", overrun, 0);
    checkOutput("resetTickMissed", tickMissed, 0);

    reset = 1'b0;
    resetF = 1'b0;
    enable = 1'b1;
    smpIf.sample_ready = 1'b1;
    periodOn = 1'b1;
    for (int i = 0; i < 10; i++) runFrame(vec0[i], vec1[i], 1'b1);
    waitDrain(50);
    checkOutput("steadyOverrunCount", overrunCount, 0);
    checkOutput("steadyTickMissed", tickMissed, 0);
    periodOn = 1'b0;

    smpIf.sample_ready = 1'b0;
    expOverrunS0 = 12'h6B2;
    runFrame(12'h111, 12'h222, 1'b0);
    runFrame(12'h6B2, 12'h4D4, 1'b1);
    repeat (2) @(negedge clk_in);
    checkOutput("overrunPulses", overrunCount, 1);
    checkOutput("validHeldWithoutReady", smpIf.sample_valid, 1);
    smpIf.sample_ready = 1'b1;
    waitDrain(50);

    applyStimulus(12'h0F0, 12'h0E1, 1'b0);
    waitCsn(1'b0, 3000);
    nRise = 0;
    prevS = sclk;
    for (int k = 0; k < 400 && nRise < 7; k++) begin
      @(negedge clk_in);
      if (sclk && !prevS) nRise++;
      prevS = sclk;
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("midResetCsn", csN, 1);
    checkOutput("midResetSclk", sclk, 1);
    checkOutput("midResetValid", smpIf.sample_valid, 0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    runFrame(12'h9C4, 12'h2B7, 1'b1);
    waitDrain(50);

    applyStimulus(12'hE07, 12'h1F8, 1'b1);
    waitCsn(1'b0, 3000);
    repeat (40) @(negedge clk_in);
    enable = 1'b0;
    waitCsn(1'b1, 400);
    waitDrain(50);
    fallsBefore = csFalls;
    repeat (3 * 2083) @(negedge clk_in);
    checkOutput("noFramesWhileDisabled", csFalls, fallsBefore);
    checkOutput("finalTickMissed", tickMissed, 0);
    checkOutput("fastTickMissed", tickMissedF, 1);
    checkOutput("fastFramesSeen", {31'd0, fastFrames > 10}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
